ram_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer for the 32x32 single-port ram (5-bit addr, 32-bit data).
- Registered cen/wen/addr/din; read data registered, appears the cycle after the access edge; ram dout forced to 0 when cen=0.
- Accepts one access at a time, drives the ram interface, and returns read data with a valid pulse to the granted requester.
- Sits between the datapath units (e.g. CPU load/store, DMA/host loader) and the ram instance.

---
 rtl/ram_ctrl_pkg.sv | 7 +
 rtl/rr_arb2.sv | 17 +
 rtl/ram_arbiter.sv | 100 ++++++++++
 tb/tb_ram_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared constants and types for the ram arbiter and its round-robin picker
package ram_ctrl_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;
    typedef logic req_idx_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin pick with last-grant memory
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic       o_win,
    output logic       o_last
);
    logic r_last;
    // on a tie the requester that did not win last time goes next
    assign o_win = (&i_req) ? ~r_last : i_req[1];
    assign o_last = r_last;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_last <= 1'b1;
        else if (i_en) r_last <= o_win;
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin sequencer for a single-port registered ram
module ram_arbiter #(
    parameter int ADDR_W = ram_ctrl_pkg::ADDR_W,
    parameter int DATA_W = ram_ctrl_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        req_i,
    input  logic [1:0]        we_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic [1:0]        gnt_o,
    output logic [1:0]        done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o,
    output logic              mem_cen_o,
    output logic              mem_wen_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_din_o,
    input  logic [DATA_W-1:0] mem_dout_i
);
    import ram_ctrl_pkg::*;
    state_t r_state, w_state;
    logic [1:0] r_gnt, w_gnt, r_done, w_done;
    logic [DATA_W-1:0] r_rdata, w_rdata, r_din, w_din;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic r_cen, w_cen, r_wen, w_wen, w_grant;
    req_idx_t w_win, w_owner;
    // the picker's last-grant flop doubles as the owner of the access in flight
    rr_arb2 u_arb (
        .clk    (clk),
        .reset_n(reset_n),
        .i_req  (req_i),
        .i_en   (w_grant),
        .o_win  (w_win),
        .o_last (w_owner)
    );
    always_comb begin
        w_state = r_state;
        w_grant = 1'b0;
        w_cen   = 1'b0;
        w_wen   = 1'b0;
        w_addr  = r_addr;
        w_din   = r_din;
        w_gnt   = 2'b00;
        w_done  = 2'b00;
        w_rdata = r_rdata;
        case (r_state)
            IDLE: if (|req_i) begin
                w_grant = 1'b1;
                w_cen   = 1'b1;
                w_wen   = we_i[w_win];
                w_addr  = w_win ? addr1_i : addr0_i;
                w_din   = w_win ? wdata1_i : wdata0_i;
                w_gnt   = {w_win, ~w_win};
                w_state = ISSUE;
            end
            ISSUE: begin
                w_done  = r_wen ? {w_owner, ~w_owner} : 2'b00;
                w_state = r_wen ? IDLE : RD_WAIT;
            end
            RD_WAIT: begin
                w_rdata = mem_dout_i;
                w_done  = {w_owner, ~w_owner};
                w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_done  <= '0;
            r_rdata <= '0;
            r_cen   <= 1'b0;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
        end else begin
            r_state <= w_state;
            r_gnt   <= w_gnt;
            r_done  <= w_done;
            r_rdata <= w_rdata;
            r_cen   <= w_cen;
            r_wen   <= w_wen;
            r_addr  <= w_addr;
            r_din   <= w_din;
        end
    assign gnt_o      = r_gnt;
    assign done_o     = r_done;
    assign rdata_o    = r_rdata;
    assign busy_o     = r_state != IDLE;
    assign mem_cen_o  = r_cen;
    assign mem_wen_o  = r_wen;
    assign mem_addr_o = r_addr;
    assign mem_din_o  = r_din;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter driving a behavioural 32x32 registered ram
module tb_ram_arbiter;
    logic clk = 1'b0, reset_n = 1'b0;
    logic [1:0] req_i = '0, we_i = '0;
    logic [4:0] addr0_i = '0, addr1_i = '0;
    logic [31:0] wdata0_i = '0, wdata1_i = '0;
    logic [1:0] gnt_o, done_o;
    logic [31:0] rdata_o, mem_din_o, mem_dout_i;
    logic busy_o, mem_cen_o, mem_wen_o;
    logic [4:0] mem_addr_o;
    logic [31:0] mem [32];
    int checks = 0, errors = 0, cyc = 0, wen_cnt = 0, k;
    typedef struct {logic [1:0] gnt; logic [1:0] done; logic rd; logic [31:0] rdata; int cyc;} ev_t;
    ev_t q[$];
    ev_t e;

    ram_arbiter dut (
        .clk(clk), .reset_n(reset_n), .req_i(req_i), .we_i(we_i),
        .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
        .gnt_o(gnt_o), .done_o(done_o), .rdata_o(rdata_o), .busy_o(busy_o),
        .mem_cen_o(mem_cen_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
        .mem_din_o(mem_din_o), .mem_dout_i(mem_dout_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ram: access on the edge where cen is seen high, dout is 0 whenever no read was done
    always @(posedge clk) begin
        if (mem_cen_o && mem_wen_o) mem[mem_addr_o] <= mem_din_o;
        mem_dout_i <= (mem_cen_o && !mem_wen_o) ? mem[mem_addr_o] : 32'h0;
    end

    always @(negedge clk) if (mem_wen_o) wen_cnt++;

    always @(negedge clk) if (reset_n && (gnt_o != 2'b00 || done_o != 2'b00)) begin
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event cyc=%0d gnt=%b done=%b", cyc, gnt_o, done_o);
        end else begin
            e = q.pop_front();
            if (gnt_o !== e.gnt || done_o !== e.done || cyc != e.cyc || (e.rd && rdata_o !== e.rdata)) begin
                errors++;
                $display("FAIL event: got gnt=%b done=%b rdata=%h cyc=%0d expected gnt=%b done=%b rdata=%h cyc=%0d",
                         gnt_o, done_o, rdata_o, cyc, e.gnt, e.done, e.rd ? e.rdata : rdata_o, e.cyc);
            end
        end
    end

    function automatic logic [1:0] oh(input int r);
        return r != 0 ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] g, input logic [1:0] d, input logic rd, input logic [31:0] rv, input int c);
        q.push_back('{g, d, rd, rv, c});
    endtask

    // d is write data for writes and the expected read data for reads
    task automatic access(input int r, input logic we, input logic [4:0] a, input logic [31:0] d);
        bit seen;
        req_i[r] = 1'b1;
        we_i[r] = we;
        if (r != 0) begin addr1_i = a; wdata1_i = d; end
        else begin addr0_i = a; wdata0_i = d; end
        push(oh(r), 2'b00, 1'b0, 32'h0, cyc + 1);
        push(2'b00, oh(r), !we, d, cyc + (we ? 2 : 3));
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin @(negedge clk); seen = gnt_o[r]; end
        if (!seen) begin checks++; errors++; $display("FAIL gnt_timeout r%0d", r); end
        @(posedge clk); #1;
        req_i[r] = 1'b0;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin @(negedge clk); seen = !busy_o; end
        if (!seen) begin checks++; errors++; $display("FAIL idle_timeout r%0d", r); end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        req_i = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", gnt_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_cen", mem_cen_o, 0);
        chk("rst_wen", mem_wen_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_din", mem_din_o, 0);
        req_i = 2'b00;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("idle_cen", mem_cen_o, 0);
        end

        wen_cnt = 0;
        access(0, 1'b1, 5'd5, 32'hDEADBEEF);
        chk("wen_pulse", wen_cnt, 1);
        access(0, 1'b0, 5'd5, 32'hDEADBEEF);
        chk("rd_rdata", rdata_o, 32'hDEADBEEF);

        access(0, 1'b1, 5'd1, 32'h11);
        access(1, 1'b1, 5'd2, 32'h22);
        k = cyc;
        req_i = 2'b11; we_i = 2'b00; addr0_i = 5'd1; addr1_i = 5'd2;
        for (int i = 0; i < 4; i++) begin
            push(oh(i % 2), 2'b00, 1'b0, 32'h0, k + 1 + 3 * i);
            push(2'b00, oh(i % 2), 1'b1, (i % 2 != 0) ? 32'h22 : 32'h11, k + 3 + 3 * i);
        end
        repeat (12) @(posedge clk);
        #1;
        req_i = 2'b00;
        repeat (2) @(posedge clk);
        #1;

        access(1, 1'b1, 5'd31, 32'hAAAA001F);
        access(1, 1'b1, 5'd0, 32'h55550000);
        chk("ram_31", mem[31], 32'hAAAA001F);
        chk("ram_0", mem[0], 32'h55550000);
        access(0, 1'b0, 5'd31, 32'hAAAA001F);
        access(1, 1'b0, 5'd0, 32'h55550000);

        req_i[0] = 1'b1; we_i[0] = 1'b1; addr0_i = 5'd5; wdata0_i = 32'h12345678;
        @(posedge clk); #2;
        chk("cen_before_reset", mem_cen_o, 1);
        reset_n = 1'b0;
        #1;
        chk("cen_async_drop", mem_cen_o, 0);
        chk("busy_after_reset", busy_o, 0);
        chk("done_after_reset", done_o, 0);
        req_i = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("ram_5_kept", mem[5], 32'hDEADBEEF);
        access(0, 1'b0, 5'd5, 32'hDEADBEEF);

        access(1, 1'b1, 5'd7, 32'hCAFE0007);
        access(0, 1'b0, 5'd7, 32'hCAFE0007);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("rdata_hold", rdata_o, 32'hCAFE0007);
            chk("idle_cen_hold", mem_cen_o, 0);
        end

        repeat (4) @(posedge clk);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
